// File: rtl/alu_pkg.sv
// Shared op codes, sequencer states and op classification for the bit-serial ALU.
package alu_pkg;

   localparam logic [2:0] OP_PASSB = 3'b000;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_AND   = 3'b100;
   localparam logic [2:0] OP_OR    = 3'b101;
   localparam logic [2:0] OP_XOR   = 3'b110;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic logic op_is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/serial_alu_bit.sv
// Combinational one-bit ALU slice: add/sub with carry, pass B and bitwise logic.
module serial_alu_bit
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic [2:0] op,
   output logic       result,
   output logic       cout
);

   logic b_eff;

   always_comb begin
      // Subtraction is A + ~B + 1; the +1 arrives as the initial carry.
      b_eff  = (op == OP_SUB) ? ~b : b;
      result = 1'b0;
      cout   = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            result = a ^ b_eff ^ cin;
            cout   = (a & b_eff) | (a & cin) | (b_eff & cin);
         end
         OP_PASSB: result = b;
         OP_AND:   result = a & b;
         OP_OR:    result = a | b;
         OP_XOR:   result = a ^ b;
         default:  result = 1'b0;
      endcase
   end

endmodule

// File: rtl/bit_serial_alu_seq.sv
// Sequencer that evaluates a WIDTH-bit ALU op one bit per clock, LSB first,
// with valid/ready handshakes on both sides and registered result/flags.
module bit_serial_alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out
);

   localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic [CW-1:0]    count;
   logic             carry;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic             bit_res;
   logic             bit_cout;

   serial_alu_bit u_slice (
      .a      (a_sh[0]),
      .b      (b_sh[0]),
      .cin    (carry),
      .op     (op_q),
      .result (bit_res),
      .cout   (bit_cout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = RUN;
         end
         RUN: begin
            if (count == LAST) state_next = DONE;
         end
         DONE: begin
            if (out_ready) begin
               in_ready   = 1'b1;
               state_next = in_valid ? RUN : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept   = in_valid && in_ready;
   assign res_next = {bit_res, res_sh[WIDTH-1:1]};
   assign result   = res_sh;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count     <= '0;
         carry     <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         op_q      <= OP_PASSB;
         res_sh    <= '0;
         out_valid <= 1'b0;
         negative  <= 1'b0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         carry_out <= 1'b0;
      end else if (accept) begin
         count     <= '0;
         carry     <= (op == OP_SUB);
         a_sh      <= a;
         b_sh      <= b;
         op_q      <= op;
         res_sh    <= '0;
         out_valid <= 1'b0;
         negative  <= 1'b0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         carry_out <= 1'b0;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         res_sh <= res_next;
         carry  <= bit_cout;
         count  <= count + 1'b1;
         if (count == LAST) begin
            out_valid <= 1'b1;
            negative  <= bit_res;
            zero      <= ~|res_next;
            // carry still holds the carry entering the MSB at this point
            overflow  <= op_is_arith(op_q) ? (carry ^ bit_cout) : 1'b0;
            carry_out <= op_is_arith(op_q) ? bit_cout : 1'b0;
         end
      end else if (state == DONE && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
